// File: rtl/cls_line_writer.sv
// PmodCLS line writer: streams an optional clear escape, a cursor-position escape
// and one text line to the SPI byte transmitter, with a fixed idle gap after each byte.
module cls_line_writer #(
   parameter int unsigned N_CHARS = 16,
   parameter int unsigned GAP     = 2000
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   START,
   input  logic                   CLR,
   input  logic                   LINE,
   input  logic [8*N_CHARS-1:0]   TEXT,
   output logic [7:0]             TX_DATA,
   output logic                   TX_VALID,
   input  logic                   TX_READY,
   output logic                   BUSY,
   output logic                   DONE
);

   localparam int unsigned IDXW = $clog2(N_CHARS + 9);
   localparam int unsigned GW   = (GAP < 2) ? 1 : $clog2(GAP + 1);

   typedef enum logic [1:0] {IDLE, SEND, WAIT, FINISH} state_t;

   state_t               state_q, state_d;
   logic [IDXW-1:0]      idx_q, idx_d;
   logic [GW-1:0]        gap_q, gap_d;
   logic                 last_q, last_d;
   logic                 clr_q, clr_d;
   logic                 line_q, line_d;
   logic [8*N_CHARS-1:0] text_q, text_d;
   logic [7:0]           tx_data_q, tx_data_d;
   logic                 tx_valid_q, tx_valid_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic [IDXW-1:0]      hdr_c;
   logic [IDXW-1:0]      rel_c;
   logic [IDXW-1:0]      tidx_c;
   logic [IDXW-1:0]      last_idx_c;
   logic [7:0]           char_c;
   logic [7:0]           byte_c;

   // Byte at idx_q: clear prefix, then cursor escape, then text leftmost first.
   always_comb begin
      hdr_c      = clr_q ? IDXW'(3) : IDXW'(0);
      last_idx_c = clr_q ? IDXW'(N_CHARS + 8) : IDXW'(N_CHARS + 5);
      rel_c      = idx_q - hdr_c;
      tidx_c     = rel_c - IDXW'(6);
      char_c     = 8'h00;
      for (int unsigned i = 0; i < N_CHARS; i++) begin
         if (tidx_c == IDXW'(i)) char_c = text_q[8*(N_CHARS-1-i) +: 8];
      end
      byte_c = char_c;
      if (clr_q && (idx_q < IDXW'(3))) begin
         case (idx_q)
            IDXW'(0): byte_c = 8'h1B;
            IDXW'(1): byte_c = 8'h5B;
            default:  byte_c = 8'h6A;
         endcase
      end else if (rel_c < IDXW'(6)) begin
         case (rel_c)
            IDXW'(0): byte_c = 8'h1B;
            IDXW'(1): byte_c = 8'h5B;
            IDXW'(2): byte_c = {7'b0011000, line_q};
            IDXW'(3): byte_c = 8'h3B;
            IDXW'(4): byte_c = 8'h30;
            default:  byte_c = 8'h48;
         endcase
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      gap_d      = gap_q;
      last_d     = last_q;
      clr_d      = clr_q;
      line_d     = line_q;
      text_d     = text_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (START) begin
               clr_d      = CLR;
               line_d     = LINE;
               text_d     = TEXT;
               idx_d      = '0;
               last_d     = 1'b0;
               tx_data_d  = 8'h1B;
               tx_valid_d = 1'b1;
               busy_d     = 1'b1;
               state_d    = SEND;
            end
         end
         SEND: begin
            if (TX_READY) begin
               tx_valid_d = 1'b0;
               gap_d      = GW'(GAP - 1);
               last_d     = (idx_q == last_idx_c);
               if (idx_q != last_idx_c) idx_d = idx_q + IDXW'(1);
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (gap_q == '0) begin
               if (last_q) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = FINISH;
               end else begin
                  tx_data_d  = byte_c;
                  tx_valid_d = 1'b1;
                  state_d    = SEND;
               end
            end else begin
               gap_d = gap_q - GW'(1);
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         gap_q      <= '0;
         last_q     <= 1'b0;
         clr_q      <= 1'b0;
         line_q     <= 1'b0;
         text_q     <= '0;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         gap_q      <= gap_d;
         last_q     <= last_d;
         clr_q      <= clr_d;
         line_q     <= line_d;
         text_q     <= text_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign TX_DATA  = tx_data_q;
   assign TX_VALID = tx_valid_q;
   assign BUSY     = busy_q;
   assign DONE     = done_q;

endmodule

// File: tb/tb_cls_line_writer.sv
// Bench for cls_line_writer (N_CHARS=4, GAP=3): expected byte lists and event
// cycles come from a queue-based model of the command stream.
module tb_cls_line_writer;

   localparam int unsigned NC = 4;
   localparam int unsigned G  = 3;

   logic          CLK = 1'b0;
   logic          RST;
   logic          START;
   logic          CLR;
   logic          LINE;
   logic [8*NC-1:0] TEXT;
   logic [7:0]    TX_DATA;
   logic          TX_VALID;
   logic          TX_READY;
   logic          BUSY;
   logic          DONE;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q[$];

   cls_line_writer #(.N_CHARS(NC), .GAP(G)) dut (
      .CLK(CLK), .RST(RST), .START(START), .CLR(CLR), .LINE(LINE), .TEXT(TEXT),
      .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
      .BUSY(BUSY), .DONE(DONE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference command stream built directly from the display protocol.
   function automatic void model(input bit c, input bit l, input logic [31:0] t);
      exp_q.delete();
      if (c) begin
         exp_q.push_back(8'h1B); exp_q.push_back(8'h5B); exp_q.push_back(8'h6A);
      end
      exp_q.push_back(8'h1B); exp_q.push_back(8'h5B);
      exp_q.push_back(l ? 8'h31 : 8'h30);
      exp_q.push_back(8'h3B); exp_q.push_back(8'h30); exp_q.push_back(8'h48);
      for (int k = NC - 1; k >= 0; k--) exp_q.push_back(t[8*k +: 8]);
   endfunction

   function automatic logic [31:0] rand_text();
      logic [31:0] t;
      for (int k = 0; k < 4; k++) t[8*k +: 8] = 8'($urandom_range(32, 126));
      return t;
   endfunction

   task automatic run_seq(input bit c, input bit l, input logic [31:0] t,
                          input bit rnd, input bit mid, input bit fin);
      logic [7:0] got[$];
      int   stalls   = 0;
      int   cyc      = 0;
      int   done_cnt = 0;
      int   gap_run  = 0;
      bit   in_gap   = 0;
      bit   pv, pr;
      logic [7:0] pd;
      model(c, l, t);
      START = 1'b1; CLR = c; LINE = l; TEXT = t; TX_READY = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      chk("accept", 64'({BUSY, TX_VALID, TX_DATA}), 64'({1'b1, 1'b1, 8'h1B}));
      while (done_cnt == 0 && cyc < 800) begin
         TX_READY = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
         if (mid && cyc == 6) begin
            START = 1'b1; TEXT = rand_text(); LINE = ~l; CLR = ~c;
         end else begin
            START = 1'b0;
         end
         pv = TX_VALID; pr = TX_READY; pd = TX_DATA;
         @(posedge CLK); #1;
         cyc++;
         if (pv && pr) begin
            chk("xfer_cycle", 64'(cyc), 64'(1 + got.size() * (G + 1) + stalls));
            got.push_back(pd);
            in_gap  = 1;
            gap_run = 0;
         end else if (pv) begin
            stalls++;
            chk("hold", 64'({TX_VALID, TX_DATA}), 64'({1'b1, pd}));
         end
         if (DONE) begin
            done_cnt++;
            chk("done_cycle", 64'(cyc), 64'(exp_q.size() * (G + 1) + stalls));
            chk("done_busy", 64'({BUSY, TX_VALID}), 64'(0));
         end else if (!TX_VALID) begin
            if (in_gap) gap_run++;
         end else if (in_gap) begin
            chk("gap_len", 64'(gap_run), 64'(G));
            in_gap = 0;
         end
      end
      START = 1'b0;
      chk("done_seen", 64'(done_cnt), 64'(1));
      chk("n_bytes", 64'(got.size()), 64'(exp_q.size()));
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         chk("byte", 64'({i[7:0], got[i]}), 64'({i[7:0], exp_q[i]}));
      START = fin;
      @(posedge CLK); #1;
      START = 1'b0;
      chk("post_done", 64'({DONE, BUSY, TX_VALID}), 64'(0));
   endtask

   initial begin
      RST = 1'b0; START = 1'b0; CLR = 1'b0; LINE = 1'b0; TEXT = '0; TX_READY = 1'b0;
      // Reset held with random inputs.
      for (int i = 0; i < 6; i++) begin
         START = 1'($urandom); CLR = 1'($urandom); LINE = 1'($urandom);
         TEXT = $urandom; TX_READY = 1'($urandom);
         @(posedge CLK); #1;
         chk("reset_hold", 64'({TX_DATA, TX_VALID, BUSY, DONE}), 64'(0));
      end
      RST = 1'b1; START = 1'b0;
      for (int i = 0; i < 100; i++) begin
         CLR = 1'($urandom); LINE = 1'($urandom); TEXT = $urandom; TX_READY = 1'($urandom);
         @(posedge CLK); #1;
         chk("idle_quiet", 64'({TX_DATA, TX_VALID, BUSY, DONE}), 64'(0));
      end

      // Directed lines.
      run_seq(1'b0, 1'b0, 32'h41424344, 1'b0, 1'b0, 1'b0);
      run_seq(1'b1, 1'b1, 32'h41424344, 1'b0, 1'b0, 1'b0);
      // Backpressure.
      run_seq(1'b0, 1'($urandom), rand_text(), 1'b1, 1'b0, 1'b0);
      run_seq(1'b1, 1'($urandom), rand_text(), 1'b1, 1'b0, 1'b0);
      // Ignored START mid-sequence and at the edge leaving FINISH, then restart.
      run_seq(1'b1, 1'b0, rand_text(), 1'b0, 1'b1, 1'b1);
      run_seq(1'b0, 1'b1, rand_text(), 1'b0, 1'b0, 1'b0);
      // Random sequences.
      for (int r = 0; r < 6; r++)
         run_seq(1'($urandom), 1'($urandom), rand_text(), 1'($urandom), 1'($urandom), 1'($urandom));

      // Asynchronous reset during the third gap.
      START = 1'b1; CLR = 1'b0; LINE = 1'b0; TEXT = rand_text(); TX_READY = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      repeat (10) @(posedge CLK);
      #1;
      chk("third_gap", 64'({BUSY, TX_VALID}), 64'({1'b1, 1'b0}));
      #2 RST = 1'b0;
      #1 chk("async_reset", 64'({TX_DATA, TX_VALID, BUSY, DONE}), 64'(0));
      @(posedge CLK); #1;
      chk("reset_held", 64'({TX_DATA, TX_VALID, BUSY, DONE}), 64'(0));
      RST = 1'b1;
      run_seq(1'b0, 1'b0, 32'h5758595A, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cls_line_writer.md
# cls_line_writer

Command sequencer for the PmodCLS character LCD. On a start request it emits, byte by byte over a valid/ready stream into the SPI master, an optional clear-display escape, a cursor-position escape for the selected row, and a fixed-length text line. It sits between the demo's top-level control logic, which supplies text and a start pulse, and the SPI byte transmitter. It enforces the inter-byte gap the display needs.

## Interface
Parameters:
- N_CHARS, 16, characters per line written (1..40)
- GAP, 2000, idle clock cycles after every accepted byte (>= 1)

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- START  in  1  request pulse; sampled only in IDLE
- CLR  in  1  1 = prefix clear sequence; sampled with START
- LINE  in  1  target row (0 or 1); sampled with START
- TEXT  in  8*N_CHARS  ASCII line; leftmost char in TEXT[8*N_CHARS-1 -: 8]; sampled with START
- TX_DATA  out  8  byte to SPI master
- TX_VALID  out  1  TX_DATA valid
- TX_READY  in  1  SPI master accepts byte
- BUSY  out  1  sequence in progress
- DONE  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SEND, WAIT, FINISH.
- IDLE: START=1 at an edge latches CLR, LINE, TEXT into internal registers, clears byte index, sets BUSY=1, TX_VALID=1 with byte 0 → SEND.
- Byte stream (n bytes total), in order:
  - if CLR: 0x1B, 0x5B, 0x6A (ESC [ j);
  - always: 0x1B, 0x5B, 0x30+LINE, 0x3B, 0x30, 0x48 (ESC [ row ; 0 H);
  - then N_CHARS text bytes, leftmost first.
- n = N_CHARS+6, or N_CHARS+9 with CLR.
- SEND: TX_VALID=1. TX_DATA is held stable until TX_VALID&TX_READY at an edge (transfer), then → WAIT with TX_VALID=0 and gap counter loaded.
- WAIT: TX_VALID=0 for exactly GAP cycles. Then:
  - more bytes remain → SEND with next byte;
  - last byte → FINISH.
- FINISH: DONE=1 and BUSY=0 for one cycle → IDLE. A START sampled at the edge leaving FINISH is not accepted; START is accepted from the following IDLE cycle onward.
- START while BUSY is ignored. Changes on TEXT/LINE/CLR after acceptance have no effect.
- TX_READY is ignored when TX_VALID=0.
- Counter widths: gap counter $clog2(GAP+1) bits; byte index $clog2(N_CHARS+9) bits. No wrap occurs within a sequence.
- Reset (RST=0, any state): immediate abort → IDLE; TX_VALID=0, TX_DATA=0x00, BUSY=0, DONE=0, latched text cleared. A partial sequence is not resumed.

## Timing
- Reset values: TX_DATA=0x00, TX_VALID=0, BUSY=0, DONE=0, state IDLE.
- START sampled at edge e0: TX_VALID and BUSY are high from e0 (one-cycle latency).
- With TX_READY held high, byte i transfers at edge e0+1+i*(GAP+1).
- DONE is high for the single cycle starting at edge e0+n*(GAP+1). BUSY falls at that same edge.
- Each TX_READY-low cycle during SEND delays all later events by one cycle.
- TX_VALID never falls without a transfer, except on reset.

## Test plan
- Reset: hold RST=0 with random inputs → TX_VALID=0, TX_DATA=0x00, BUSY=0, DONE=0. Release, START=0 for 100 cycles → outputs unchanged.
- N_CHARS=4, GAP=3, CLR=0, LINE=0, TEXT="ABCD", TX_READY=1 → bytes 1B 5B 30 3B 30 48 41 42 43 44 on edges e0+1, +5, +9, ... DONE high at e0+40 for one cycle only.
- CLR=1, LINE=1, same text → 1B 5B 6A 1B 5B 31 3B 30 48 41 42 43 44 (13 bytes). DONE at e0+52.
- Backpressure: TX_READY random, ~30% high → TX_DATA constant while TX_VALID=1 and unaccepted. Exactly 10 transfers in order. At least GAP low-valid cycles between each pair of transfers.
- START and new TEXT pulsed mid-sequence, and START pulsed at the edge leaving FINISH → both ignored; original bytes only, one DONE. A START in the next IDLE cycle begins a new sequence.
- RST=0 during the 3rd gap, then release and START with TEXT="WXYZ" → outputs zero immediately. The new sequence starts from byte 0x1B, with no leftover bytes.
